branch_pc_unit: RTL and testbench

Program-counter and control-transfer resolution unit for the MIPS pipeline. Consumes the 3-bit branch/jump code and link request produced by the main controller, evaluates the branch condition on register operands in EX, and owns the PC register. It drives the fetch address, a flush for wrong-path instructions after a redirect, a link-register write for jal, and a saturating count of taken transfers.

---
 rtl/branch_pc_unit.sv | 121 ++++++++++++
 tb/tb_branch_pc_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program-counter owner and control-transfer resolver for the MIPS pipeline.
// Evaluates branch/jump conditions in EX, redirects fetch, flushes wrong-path work and drives jal link writes.
module branch_pc_unit #(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Valid,
  input  logic [2:0]  BranchJump,
  input  logic        Link,
  input  logic [31:0] PCPlus4_EX,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RsVal,
  input  logic [31:0] RtVal,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        LinkWrite,
  output logic [31:0] LinkAddr,
  output logic [15:0] TakenCount
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] BJ_JUMP  = 3'b011;

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic [31:0] pc_next, link_addr_next, target;
  logic [15:0] count_next;
  logic        flush_next, link_write_next;
  logic        cond, taken, is_jal;

  assign PCPlus4 = PC + 32'd4;

  // Branch conditions treat RsVal as signed; 000 and 111 never transfer.
  always_comb begin
    cond = 1'b0;
    case (BranchJump)
      3'b001:  cond = (RsVal == RtVal);
      3'b010:  cond = (RsVal != RtVal);
      3'b011:  cond = 1'b1;
      3'b100:  cond = !RsVal[31];
      3'b101:  cond = !RsVal[31] && (RsVal != 32'd0);
      3'b110:  cond = RsVal[31] || (RsVal == 32'd0);
      default: cond = 1'b0;
    endcase
  end

  assign target = (BranchJump == BJ_JUMP) ? {PCPlus4_EX[31:28], JumpIndex, 2'b00}
                                          : PCPlus4_EX + (BranchOffset << 2);
  assign taken  = Valid && !Stall && (state == RUN) && cond;
  assign is_jal = taken && (BranchJump == BJ_JUMP) && Link;

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    pc_next         = PC;
    flush_next      = Flush;
    link_write_next = LinkWrite;
    link_addr_next  = LinkAddr;
    count_next      = TakenCount;
    if (!Stall) begin
      link_write_next = 1'b0;
      case (state)
        RUN: begin
          if (taken) begin
            pc_next    = target;
            flush_next = 1'b1;
            cnt_next   = CNT_INIT;
            // A single-cycle flush needs no FLUSH state; RUN clears Flush on the next cycle.
            state_next = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            if (is_jal) begin
              link_write_next = 1'b1;
              link_addr_next  = PCPlus4_EX;
            end
            if (TakenCount != 16'hFFFF) count_next = TakenCount + 16'd1;
          end else begin
            pc_next    = PCPlus4;
            flush_next = 1'b0;
          end
        end
        FLUSH: begin
          pc_next = PCPlus4;
          if (cnt == 3'd0) begin
            flush_next = 1'b0;
            state_next = RUN;
          end else begin
            cnt_next = cnt - 3'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= RUN;
      cnt        <= 3'd0;
      PC         <= PC_RESET;
      Flush      <= 1'b0;
      LinkWrite  <= 1'b0;
      LinkAddr   <= 32'd0;
      TakenCount <= 16'd0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      PC         <= pc_next;
      Flush      <= flush_next;
      LinkWrite  <= link_write_next;
      LinkAddr   <= link_addr_next;
      TakenCount <= count_next;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: one instance with a single-cycle flush, one with a three-cycle flush.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, valid, link;
  logic [2:0]  branchJump;
  logic [31:0] pcPlus4Ex, branchOffset, rsVal, rtVal;
  logic [25:0] jumpIndex;

  logic [31:0] pc0, pcPlus40, linkAddr0, pc1, pcPlus41, linkAddr1;
  logic        flush0, linkWrite0, flush1, linkWrite1;
  logic [15:0] takenCount0, takenCount1;

  int totalChecks = 0;
  int badChecks   = 0;
  int flushSeen;
  logic [31:0] expPc;
  logic [15:0] expCount;

  always #5 clk = ~clk;

  branch_pc_unit #(.PC_RESET(32'h0), .FLUSH_CYCLES(1)) u0 (
    .Clk(clk), .Rst(rst), .Stall(stall), .Valid(valid), .BranchJump(branchJump),
    .Link(link), .PCPlus4_EX(pcPlus4Ex), .BranchOffset(branchOffset),
    .JumpIndex(jumpIndex), .RsVal(rsVal), .RtVal(rtVal), .PC(pc0),
    .PCPlus4(pcPlus40), .Flush(flush0), .LinkWrite(linkWrite0),
    .LinkAddr(linkAddr0), .TakenCount(takenCount0)
  );

  branch_pc_unit #(.PC_RESET(32'h0), .FLUSH_CYCLES(3)) u1 (
    .Clk(clk), .Rst(rst), .Stall(stall), .Valid(valid), .BranchJump(branchJump),
    .Link(link), .PCPlus4_EX(pcPlus4Ex), .BranchOffset(branchOffset),
    .JumpIndex(jumpIndex), .RsVal(rsVal), .RtVal(rtVal), .PC(pc1),
    .PCPlus4(pcPlus41), .Flush(flush1), .LinkWrite(linkWrite1),
    .LinkAddr(linkAddr1), .TakenCount(takenCount1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] bj, input logic lk,
                               input logic [31:0] p4, input logic [31:0] off,
                               input logic [25:0] idx, input logic [31:0] rs,
                               input logic [31:0] rt);
    valid        = v;
    branchJump   = bj;
    link         = lk;
    pcPlus4Ex    = p4;
    branchOffset = off;
    jumpIndex    = idx;
    rsVal        = rs;
    rtVal        = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
  endtask

  task automatic checkResetValues(input string who, input logic [31:0] p, input logic [31:0] p4,
                                  input logic f, input logic lw, input logic [31:0] la,
                                  input logic [15:0] tc);
    checkOutput({who, "_pc"}, p, 32'h0);
    checkOutput({who, "_pcplus4"}, p4, 32'h4);
    checkOutput({who, "_flush"}, {31'd0, f}, 32'd0);
    checkOutput({who, "_linkwrite"}, {31'd0, lw}, 32'd0);
    checkOutput({who, "_linkaddr"}, la, 32'd0);
    checkOutput({who, "_count"}, {16'd0, tc}, 32'd0);
  endtask

  // Condition table: code, rs, rt, valid, expected taken.
  logic [2:0]  tabCode  [14] = '{3'b101, 3'b101, 3'b101, 3'b110, 3'b110, 3'b110,
                                 3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b111,
                                 3'b000, 3'b011};
  logic [31:0] tabRs    [14] = '{32'h0, 32'h1, 32'h8000_0000, 32'h0, 32'h1, 32'h8000_0000,
                                 32'h0, 32'h1, 32'h8000_0000, 32'h5, 32'h5, 32'h5,
                                 32'h5, 32'h5};
  logic [31:0] tabRt    [14] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h6, 32'h5, 32'h5,
                                 32'h5, 32'h5};
  logic        tabValid [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic        tabTaken [14] = '{0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0};

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stall = 1'b0;
    rst   = 1'b1;
    idle();
    tick();
    checkResetValues("reset", pc0, pcPlus40, flush0, linkWrite0, linkAddr0, takenCount0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("idle_pc", pc0, 32'(i * 4));
      checkOutput("idle_flush", {31'd0, flush0}, 32'd0);
    end
    checkOutput("idle_count", {16'd0, takenCount0}, 32'd0);

    // beq taken with a negative offset, then not taken.
    applyStimulus(1'b1, 3'b001, 1'b0, 32'h100, 32'hFFFF_FFFE, 26'h0, 32'd5, 32'd5);
    tick();
    checkOutput("beq_pc", pc0, 32'hF8);
    checkOutput("beq_flush", {31'd0, flush0}, 32'd1);
    checkOutput("beq_count", {16'd0, takenCount0}, 32'd1);
    idle();
    tick();
    checkOutput("beq_after_pc", pc0, 32'hFC);
    checkOutput("beq_after_flush", {31'd0, flush0}, 32'd0);
    applyStimulus(1'b1, 3'b001, 1'b0, 32'h100, 32'hFFFF_FFFE, 26'h0, 32'd5, 32'd6);
    tick();
    checkOutput("beq_nt_pc", pc0, 32'h100);
    checkOutput("beq_nt_flush", {31'd0, flush0}, 32'd0);
    checkOutput("beq_nt_count", {16'd0, takenCount0}, 32'd1);

    // Stall coincident with a taken condition defers resolution.
    stall = 1'b1;
    applyStimulus(1'b1, 3'b001, 1'b0, 32'h100, 32'hFFFF_FFFE, 26'h0, 32'd5, 32'd5);
    tick();
    checkOutput("stall_pc", pc0, 32'h100);
    checkOutput("stall_count", {16'd0, takenCount0}, 32'd1);
    stall = 1'b0;
    tick();
    checkOutput("unstall_pc", pc0, 32'hF8);
    checkOutput("unstall_flush", {31'd0, flush0}, 32'd1);
    checkOutput("unstall_count", {16'd0, takenCount0}, 32'd2);
    idle();
    tick();

    expPc    = 32'hFC;
    expCount = 16'd2;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tabValid[i], tabCode[i], 1'b0, 32'h200, 32'h0, 26'h0, tabRs[i], tabRt[i]);
      tick();
      expPc    = tabTaken[i] ? 32'h200 : expPc + 32'd4;
      expCount = expCount + {15'd0, tabTaken[i]};
      checkOutput($sformatf("cond%0d_pc", i), pc0, expPc);
      checkOutput($sformatf("cond%0d_flush", i), {31'd0, flush0}, {31'd0, tabTaken[i]});
      checkOutput($sformatf("cond%0d_count", i), {16'd0, takenCount0}, {16'd0, expCount});
      idle();
      tick();
      expPc = expPc + 32'd4;
    end

    // jal, then Link with a non-jump code.
    applyStimulus(1'b1, 3'b011, 1'b1, 32'h4000_0010, 32'h0, 26'h0000123, 32'h0, 32'h0);
    tick();
    checkOutput("jal_pc", pc0, 32'h4000_048C);
    checkOutput("jal_linkwrite", {31'd0, linkWrite0}, 32'd1);
    checkOutput("jal_linkaddr", linkAddr0, 32'h4000_0010);
    idle();
    tick();
    checkOutput("jal_after_pc", pc0, 32'h4000_0490);
    checkOutput("jal_after_linkwrite", {31'd0, linkWrite0}, 32'd0);
    checkOutput("jal_after_linkaddr", linkAddr0, 32'h4000_0010);
    applyStimulus(1'b1, 3'b001, 1'b1, 32'h300, 32'h0, 26'h0, 32'd7, 32'd7);
    tick();
    checkOutput("beqlink_pc", pc0, 32'h300);
    checkOutput("beqlink_linkwrite", {31'd0, linkWrite0}, 32'd0);
    checkOutput("beqlink_linkaddr", linkAddr0, 32'h4000_0010);
    idle();
    tick();

    // Jump to the top of the address space, then wrap sequentially.
    applyStimulus(1'b1, 3'b011, 1'b0, 32'hF000_0000, 32'h0, 26'h3FF_FFFF, 32'h0, 32'h0);
    tick();
    checkOutput("wrap_pc", pc0, 32'hFFFF_FFFC);
    checkOutput("wrap_pcplus4", pcPlus40, 32'h0);
    idle();
    tick();
    checkOutput("wrapped_pc", pc0, 32'h0);
    checkOutput("wrapped_pcplus4", pcPlus40, 32'h4);

    // Three-cycle flush with a two-cycle stall and an ignored second jump.
    rst = 1'b1;
    tick();
    checkResetValues("u1reset", pc1, pcPlus41, flush1, linkWrite1, linkAddr1, takenCount1);
    rst = 1'b0;
    flushSeen = 0;
    applyStimulus(1'b1, 3'b011, 1'b0, 32'h10, 32'h0, 26'h40, 32'h0, 32'h0);
    tick();
    flushSeen += flush1;
    checkOutput("fl_redirect_pc", pc1, 32'h100);
    idle();
    tick();
    flushSeen += flush1;
    checkOutput("fl_second_pc", pc1, 32'h104);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      flushSeen += flush1;
      checkOutput("fl_stall_pc", pc1, 32'h104);
      checkOutput("fl_stall_flush", {31'd0, flush1}, 32'd1);
    end
    stall = 1'b0;
    applyStimulus(1'b1, 3'b011, 1'b0, 32'h10, 32'h0, 26'h40, 32'h0, 32'h0);
    tick();
    flushSeen += flush1;
    checkOutput("fl_ignored_pc", pc1, 32'h108);
    checkOutput("fl_ignored_count", {16'd0, takenCount1}, 32'd1);
    idle();
    tick();
    flushSeen += flush1;
    checkOutput("fl_end_flush", {31'd0, flush1}, 32'd0);
    checkOutput("fl_end_pc", pc1, 32'h10C);
    checkOutput("fl_total_cycles", 32'(flushSeen), 32'd5);

    // Saturation of the taken counter with back-to-back jumps.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 3'b011, 1'b0, 32'h10, 32'h0, 26'h40, 32'h0, 32'h0);
    repeat (65534) tick();
    checkOutput("sat_fffe", {16'd0, takenCount0}, 32'h0000_FFFE);
    tick();
    checkOutput("sat_ffff", {16'd0, takenCount0}, 32'h0000_FFFF);
    repeat (2) tick();
    checkOutput("sat_hold", {16'd0, takenCount0}, 32'h0000_FFFF);

    // Reset while mid-flush and with a jal asserted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 3'b011, 1'b1, 32'h10, 32'h0, 26'h40, 32'h0, 32'h0);
    tick();
    checkOutput("midflush_flush", {31'd0, flush1}, 32'd1);
    checkOutput("midflush_linkwrite", {31'd0, linkWrite1}, 32'd1);
    rst = 1'b1;
    tick();
    checkResetValues("rst_u0", pc0, pcPlus40, flush0, linkWrite0, linkAddr0, takenCount0);
    checkResetValues("rst_u1", pc1, pcPlus41, flush1, linkWrite1, linkAddr1, takenCount1);
    rst = 1'b0;
    idle();
    tick();
    checkOutput("post_rst_pc", pc1, 32'h4);
    checkOutput("post_rst_flush", {31'd0, flush1}, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
